spi_regs: RTL and testbench
===========================

SPI_REGS -- requirements
Module: spi_regs

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per FIFO; legal values are 2, 4 or 8.
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, meaning the constant returned by the ID register.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reg_we  input  1  one-cycle write strobe from the SPI slave.
REQ-006 reg_re  input  1  one-cycle read strobe from the SPI slave.
REQ-007 reg_addr  input  7  register address, valid while reg_we or reg_re is high.
REQ-008 reg_wd  input  8  write data, valid with reg_we.
REQ-009 reg_rd  output  8  registered read data returned to the SPI slave.
REQ-010 tx_data  output  8  head of the TX FIFO (SPI to local direction).
REQ-011 tx_valid  output  1  TX FIFO not empty.
REQ-012 tx_ready  input  1  local consumer accepts tx_data.
REQ-013 rx_data  input  8  byte from the local producer.
REQ-014 rx_valid  input  1  rx_data is valid.
REQ-015 rx_ready  output  1  RX FIFO not full.
REQ-016 ctrl_out  output  6  CTRL[7:2].
REQ-017 irq  output  1  registered interrupt request.

Function
REQ-018 Register map (all other addresses read 8'h00 and ignore writes):
- 0x00 ID, RO, returns ID_VALUE.
- 0x01 SCRATCH, RW.
- 0x02 CTRL, RW. Bit0 tx_flush and bit1 rx_flush are self-clearing and always read 0.
- 0x03 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_avail, [4] tx_ovf, [5] rx_unf, [6] rx_ovf, [7] 0. Bits 6:4 are sticky; writing 1 to a sticky bit clears it.
- 0x04 IRQ_MASK, RW.
- 0x05 TX_DATA, WO; a write pushes to the TX FIFO.
- 0x06 RX_DATA, RO; a read pops the RX FIFO.
- 0x07 LEVELS, RO: [3:0] TX count, [7:4] RX count.
REQ-019 On a clk edge with reg_re high, reg_rd SHALL load the value at reg_addr; reg_rd then holds until the next reg_re.
REQ-020 Read-data latency is 1 clk; a pop caused by reading RX_DATA takes effect on the same edge.
REQ-021 Reading RX_DATA while the RX FIFO is empty SHALL return 8'h00, set rx_unf and not disturb the FIFO pointers.
REQ-022 A TX_DATA write when the TX FIFO is full and tx_ready&tx_valid is low SHALL drop the byte and set tx_ovf.
REQ-023 A TX_DATA write when the TX FIFO is full and a local pop happens the same cycle SHALL be accepted; the count is unchanged.
REQ-024 An rx_valid byte when the RX FIFO is full SHALL be dropped and set rx_ovf, unless an RX_DATA pop happens the same cycle, in which case it is accepted.
REQ-025 An RX_DATA read on an empty FIFO in the same cycle as an rx_valid push SHALL still underflow (no bypass); the pushed byte is stored.
REQ-026 A flush SHALL empty the FIFO on the next edge; a push in the same cycle as its flush is discarded without setting any flag.
REQ-027 A sticky-flag set and a W1C clear of the same bit in the same cycle SHALL leave the bit set.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; counts range 0..FIFO_DEPTH.
REQ-029 reg_we and reg_re both high SHALL perform both operations; reg_re takes its data from the pre-write state.

Reset
REQ-030 Reset SHALL force: reg_rd=0, SCRATCH=0, CTRL=0, IRQ_MASK=0, sticky flags=0, both FIFOs empty, tx_valid=0, rx_ready=1, irq=0.
REQ-031 Reset asserted mid-transfer SHALL discard all FIFO contents; no flags are set.

Configuration
REQ-032 With SPI_REGS_IRQ_EN defined, irq SHALL equal the registered value of |(STATUS & IRQ_MASK), asserting 1 clk after its cause.
REQ-033 Without SPI_REGS_IRQ_EN, irq SHALL be tied 0, IRQ_MASK SHALL read 0, and writes to IRQ_MASK are ignored.

Structure
REQ-034 Package spi_regs_pkg SHALL hold the register address constants, the STATUS bit indices and the ID default.
REQ-035 Both FIFOs SHALL be instances of one sub-module spi_regs_fifo (parameter DEPTH; ports push, pop, flush, full, empty, count, head data).

Verification
REQ-036 Write 0x3C to 0x01, then read 0x01 -> reg_rd=0x3C one clk after reg_re; read 0x00 -> 0xA5.
REQ-037 Nine TX_DATA writes 0x10..0x18 with tx_ready=0 -> LEVELS[3:0]=8, tx_full=1, tx_ovf=1, and the drained sequence is 0x10..0x17.
REQ-038 Read RX_DATA on an empty FIFO -> reg_rd=0x00, STATUS=0x22; write 0x20 to STATUS -> STATUS=0x02.
REQ-039 Push 0x55 via rx_valid, then read 0x06 -> reg_rd=0x55, rx_avail returns to 0.
REQ-040 With IRQ_MASK=0x08, push one RX byte -> irq high 2 clks after rx_valid; pop it -> irq low 1 clk after the pop.
REQ-041 Write CTRL=0x01 with the TX FIFO full -> TX count=0 on the next edge, CTRL reads 0x00, ctrl_out=0.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Shared constants for the SPI register block: register addresses, STATUS bit
// positions and the default ID byte.
package spi_regs_pkg;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

  localparam logic [6:0] ADDR_ID       = 7'h00;
  localparam logic [6:0] ADDR_SCRATCH  = 7'h01;
  localparam logic [6:0] ADDR_CTRL     = 7'h02;
  localparam logic [6:0] ADDR_STATUS   = 7'h03;
  localparam logic [6:0] ADDR_IRQ_MASK = 7'h04;
  localparam logic [6:0] ADDR_TX_DATA  = 7'h05;
  localparam logic [6:0] ADDR_RX_DATA  = 7'h06;
  localparam logic [6:0] ADDR_LEVELS   = 7'h07;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_AVAIL = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_RX_OVF   = 6;

endpackage

// File: rtl/spi_regs_fifo.sv
// Byte FIFO with flush; a pop of a non-empty FIFO frees room for a push in the
// same cycle, and a flush discards any push issued alongside it.
module spi_regs_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [3:0] count_o,
  output logic [7:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [3:0]    count_q;
  logic          doPush, doPop;

  assign full_o  = (count_q == 4'(DEPTH));
  assign empty_o = (count_q == 4'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  assign doPop  = pop_i & ~empty_o & ~flush_i;
  assign doPush = push_i & ~flush_i & (~full_o | doPop);

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= 4'd0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_q + 4'(doPush) - 4'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/spi_regs.sv
// SPI-facing register file with TX/RX byte FIFOs and sticky error flags.
// Define SPI_REGS_IRQ_EN to enable IRQ_MASK and the irq output.
module spi_regs
  import spi_regs_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_we,
  input  logic       reg_re,
  input  logic [6:0] reg_addr,
  input  logic [7:0] reg_wd,
  output logic [7:0] reg_rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [5:0] ctrl_out,
  output logic       irq
);

  logic       txWrite, rxRead, ctrlWrite, statusWrite, maskWrite;
  logic       txPop, txFlush, rxFlush;
  logic       txFull, txEmpty, rxFull, rxEmpty;
  logic [3:0] txCount, rxCount;
  logic [7:0] txHead, rxHead;
  logic [7:0] scratch_q, regRd_q, status, readValue, irqMaskView;
  logic [5:0] ctrl_q;
  logic [2:0] sticky_q, sticky_d, stickySet, stickyClr;

  assign txWrite     = reg_we && (reg_addr == ADDR_TX_DATA);
  assign ctrlWrite   = reg_we && (reg_addr == ADDR_CTRL);
  assign statusWrite = reg_we && (reg_addr == ADDR_STATUS);
  assign maskWrite   = reg_we && (reg_addr == ADDR_IRQ_MASK);
  assign rxRead      = reg_re && (reg_addr == ADDR_RX_DATA);
  assign txPop       = tx_ready & tx_valid;
  assign txFlush     = ctrlWrite & reg_wd[0];
  assign rxFlush     = ctrlWrite & reg_wd[1];

  spi_regs_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
    .clk(clk), .reset(reset), .push_i(txWrite), .pop_i(txPop), .flush_i(txFlush),
    .data_i(reg_wd), .full_o(txFull), .empty_o(txEmpty), .count_o(txCount), .head_o(txHead)
  );

  spi_regs_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
    .clk(clk), .reset(reset), .push_i(rx_valid), .pop_i(rxRead), .flush_i(rxFlush),
    .data_i(rx_data), .full_o(rxFull), .empty_o(rxEmpty), .count_o(rxCount), .head_o(rxHead)
  );

  assign tx_data  = txHead;
  assign tx_valid = ~txEmpty;
  assign rx_ready = ~rxFull;
  assign ctrl_out = ctrl_q;
  assign reg_rd   = regRd_q;

  // Sticky bits held as {rx_ovf, rx_unf, tx_ovf}; a same-cycle set wins over W1C
  always_comb begin
    stickySet = {rx_valid & rxFull & ~rxRead & ~rxFlush,
                 rxRead & rxEmpty,
                 txWrite & txFull & ~txPop};
    stickyClr = statusWrite ? {reg_wd[ST_RX_OVF], reg_wd[ST_RX_UNF], reg_wd[ST_TX_OVF]} : 3'b000;
    sticky_d  = (sticky_q & ~stickyClr) | stickySet;
  end

  always_comb begin
    status              = 8'h00;
    status[ST_TX_FULL]  = txFull;
    status[ST_TX_EMPTY] = txEmpty;
    status[ST_RX_FULL]  = rxFull;
    status[ST_RX_AVAIL] = ~rxEmpty;
    status[ST_TX_OVF]   = sticky_q[0];
    status[ST_RX_UNF]   = sticky_q[1];
    status[ST_RX_OVF]   = sticky_q[2];
  end

  always_comb begin
    readValue = 8'h00;
    case (reg_addr)
      ADDR_ID:       readValue = ID_VALUE;
      ADDR_SCRATCH:  readValue = scratch_q;
      ADDR_CTRL:     readValue = {ctrl_q, 2'b00};
      ADDR_STATUS:   readValue = status;
      ADDR_IRQ_MASK: readValue = irqMaskView;
      ADDR_RX_DATA:  readValue = rxEmpty ? 8'h00 : rxHead;
      ADDR_LEVELS:   readValue = {rxCount, txCount};
      default:       readValue = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= 8'h00;
      ctrl_q    <= 6'd0;
      sticky_q  <= 3'b000;
      regRd_q   <= 8'h00;
    end else begin
      if (reg_we && (reg_addr == ADDR_SCRATCH)) scratch_q <= reg_wd;
      if (ctrlWrite) ctrl_q <= reg_wd[7:2];
      sticky_q <= sticky_d;
      if (reg_re) regRd_q <= readValue;
    end
  end

`ifdef SPI_REGS_IRQ_EN
  logic [7:0] irqMask_q;
  logic       irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irqMask_q <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      if (maskWrite) irqMask_q <= reg_wd;
      irq_q <= |(status & irqMask_q);
    end
  end

  assign irqMaskView = irqMask_q;
  assign irq         = irq_q;
`else
  logic unusedMaskWrite;
  assign unusedMaskWrite = maskWrite;
  assign irqMaskView     = 8'h00;
  assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regs.sv
// Self-checking bench for spi_regs: directed and random register/FIFO traffic
// checked against a queue-based model of the register map.
module tb_spi_regs;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reg_we = 1'b0, reg_re = 1'b0;
  logic [6:0] reg_addr = 7'h00;
  logic [7:0] reg_wd = 8'h00;
  logic [7:0] reg_rd, tx_data, rx_data = 8'h00;
  logic       tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready, irq;
  logic [5:0] ctrl_out;

  spi_regs dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wd(reg_wd), .reg_rd(reg_rd), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ctrl_out(ctrl_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int totalCount = 0;

  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic       txOvf = 1'b0, rxUnf = 1'b0, rxOvf = 1'b0;
  logic [7:0] scratchM = 8'h00, ctrlM = 8'h00, maskM = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] modelStatus();
    return {1'b0, rxOvf, rxUnf, txOvf, rxQ.size() != 0, rxQ.size() == D,
            txQ.size() == 0, txQ.size() == D};
  endfunction

  function automatic logic [7:0] modelRead(input logic [6:0] a);
    case (a)
      7'h00: return 8'hA5;
      7'h01: return scratchM;
      7'h02: return ctrlM;
      7'h03: return modelStatus();
`ifdef SPI_REGS_IRQ_EN
      7'h04: return maskM;
`endif
      7'h06: return (rxQ.size() == 0) ? 8'h00 : rxQ[0];
      7'h07: return {4'(rxQ.size()), 4'(txQ.size())};
      default: return 8'h00;
    endcase
  endfunction

  function automatic void modelWrite(input logic [6:0] a, input logic [7:0] d);
    case (a)
      7'h01: scratchM = d;
      7'h02: begin
        ctrlM = d & 8'hFC;
        if (d[0]) txQ.delete();
        if (d[1]) rxQ.delete();
      end
      7'h03: begin
        if (d[4]) txOvf = 1'b0;
        if (d[5]) rxUnf = 1'b0;
        if (d[6]) rxOvf = 1'b0;
      end
      7'h04: maskM = d;
      7'h05: if (txQ.size() < D) txQ.push_back(d); else txOvf = 1'b1;
      default: ;
    endcase
  endfunction

  task automatic regWrite(input logic [6:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wd = d;
    tick();
    reg_we = 1'b0;
    modelWrite(a, d);
  endtask

  task automatic regRead(input logic [6:0] a, input string tag);
    logic [7:0] exp;
    exp = modelRead(a);
    reg_re = 1'b1; reg_addr = a;
    tick();
    reg_re = 1'b0;
    if (a == 7'h06) begin
      if (rxQ.size() == 0) rxUnf = 1'b1;
      else rxQ.delete(0);
    end
    checkOutput(tag, 32'(reg_rd), 32'(exp));
  endtask

  task automatic rxPush(input logic [7:0] b);
    checkOutput("rx_ready", 32'(rx_ready), 32'(rxQ.size() < D));
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
    if (rxQ.size() < D) rxQ.push_back(b); else rxOvf = 1'b1;
  endtask

  task automatic drainOne();
    checkOutput("tx_valid", 32'(tx_valid), 32'(txQ.size() != 0));
    if (txQ.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(txQ[0]));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    if (txQ.size() != 0) txQ.delete(0);
  endtask

  // One randomly chosen register or local-side operation per call
  task automatic applyStimulus();
    logic [7:0] b;
    b = 8'($urandom);
    case ($urandom_range(0, 6))
      0: regWrite(7'h05, b);
      1: rxPush(b);
      2: regRead(7'h06, "rnd_rx_read");
      3: drainOne();
      4: regRead(7'h03, "rnd_status");
      5: regRead(7'($urandom_range(0, 9)), "rnd_read");
      default: regWrite(7'h03, b & 8'h70);
    endcase
  endtask

  initial begin
    logic [7:0] b, exp;

    tick(); tick();
    reset = 1'b0;
    checkOutput("reset_reg_rd", 32'(reg_rd), 32'h00);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'h1);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_ctrl_out", 32'(ctrl_out), 32'h0);
    regRead(7'h03, "reset_status");
    regRead(7'h07, "reset_levels");

    regWrite(7'h01, 8'h3C);
    regRead(7'h01, "scratch");
    checkOutput("scratch_const", 32'(reg_rd), 32'h3C);
    regRead(7'h00, "id");
    checkOutput("id_const", 32'(reg_rd), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      regWrite(7'h01, 8'($urandom));
      regRead(7'h01, "scratch_rnd");
    end

    // Same-cycle write and read of SCRATCH returns the old value
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = 7'h01; reg_wd = 8'h9E;
    exp = scratchM;
    tick();
    reg_we = 1'b0; reg_re = 1'b0;
    modelWrite(7'h01, 8'h9E);
    checkOutput("we_re_old", 32'(reg_rd), 32'(exp));
    regRead(7'h01, "we_re_new");

    for (int i = 0; i < 9; i++) regWrite(7'h05, 8'(8'h10 + i));
    regRead(7'h07, "tx_levels_full");
    checkOutput("tx_count_8", 32'(reg_rd[3:0]), 32'd8);
    regRead(7'h03, "tx_full_ovf");
    checkOutput("tx_ovf_bits", 32'(reg_rd & 8'h11), 32'h11);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_seq", 32'(tx_data), 32'(8'h10 + i));
      drainOne();
    end
    drainOne();
    regWrite(7'h03, 8'h10);

    regRead(7'h06, "rx_unf_data");
    regRead(7'h03, "status_unf");
    checkOutput("status_22", 32'(reg_rd), 32'h22);
    regWrite(7'h03, 8'h20);
    regRead(7'h03, "status_w1c");
    checkOutput("status_02", 32'(reg_rd), 32'h02);

    rxPush(8'h55);
    regRead(7'h06, "rx_55");
    regRead(7'h03, "rx_avail_clear");

    for (int i = 0; i < 60; i++) applyStimulus();

    // Fill both FIFOs, then exercise the full-boundary corner cases
    regWrite(7'h02, 8'h03);
    regWrite(7'h03, 8'h70);
    for (int i = 0; i < D; i++) regWrite(7'h05, 8'($urandom));
    for (int i = 0; i < D; i++) rxPush(8'($urandom));

    b = 8'($urandom);
    checkOutput("tx_head_pre", 32'(tx_data), 32'(txQ[0]));
    tx_ready = 1'b1; reg_we = 1'b1; reg_addr = 7'h05; reg_wd = b;
    tick();
    tx_ready = 1'b0; reg_we = 1'b0;
    txQ.delete(0); txQ.push_back(b);
    regRead(7'h07, "tx_full_pushpop");

    b = 8'($urandom);
    exp = rxQ[0];
    rx_valid = 1'b1; rx_data = b; reg_re = 1'b1; reg_addr = 7'h06;
    tick();
    rx_valid = 1'b0; reg_re = 1'b0;
    rxQ.delete(0); rxQ.push_back(b);
    checkOutput("rx_full_pushpop_data", 32'(reg_rd), 32'(exp));
    regRead(7'h03, "rx_full_pushpop_status");

    rx_valid = 1'b1; rx_data = 8'hEE; reg_we = 1'b1; reg_addr = 7'h03; reg_wd = 8'h40;
    tick();
    rx_valid = 1'b0; reg_we = 1'b0;
    rxOvf = 1'b1;
    regRead(7'h03, "sticky_set_wins");

    regWrite(7'h03, 8'h70);
    rx_valid = 1'b1; rx_data = 8'hDD; reg_we = 1'b1; reg_addr = 7'h02; reg_wd = 8'h02;
    tick();
    rx_valid = 1'b0; reg_we = 1'b0;
    modelWrite(7'h02, 8'h02);
    regRead(7'h07, "rx_flush_push");
    regRead(7'h03, "rx_flush_noflag");

    regWrite(7'h02, 8'h01);
    regRead(7'h07, "tx_flush_levels");
    checkOutput("tx_flush_count0", 32'(reg_rd[3:0]), 32'd0);
    regRead(7'h02, "ctrl_selfclear");
    checkOutput("ctrl_out_zero", 32'(ctrl_out), 32'h0);
    regWrite(7'h02, 8'hFC);
    regRead(7'h02, "ctrl_fc");
    checkOutput("ctrl_out_3f", 32'(ctrl_out), 32'h3F);
    regWrite(7'h02, 8'h00);

`ifdef SPI_REGS_IRQ_EN
    regWrite(7'h04, 8'h08);
    regRead(7'h04, "irq_mask");
    rxPush(8'h77);
    checkOutput("irq_1clk", 32'(irq), 32'h0);
    tick();
    checkOutput("irq_2clk", 32'(irq), 32'h1);
    regRead(7'h06, "irq_pop");
    tick();
    checkOutput("irq_low", 32'(irq), 32'h0);
`else
    regWrite(7'h04, 8'hFF);
    regRead(7'h04, "mask_disabled");
    tick();
    checkOutput("irq_tied", 32'(irq), 32'h0);
`endif

    // Reset in the middle of traffic discards everything
    for (int i = 0; i < 3; i++) regWrite(7'h05, 8'($urandom));
    for (int i = 0; i < 3; i++) rxPush(8'($urandom));
    regWrite(7'h01, 8'h81);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    txQ.delete(); rxQ.delete();
    txOvf = 1'b0; rxUnf = 1'b0; rxOvf = 1'b0;
    scratchM = 8'h00; ctrlM = 8'h00; maskM = 8'h00;
    checkOutput("midreset_reg_rd", 32'(reg_rd), 32'h00);
    checkOutput("midreset_tx_valid", 32'(tx_valid), 32'h0);
    regRead(7'h07, "midreset_levels");
    regRead(7'h03, "midreset_status");
    regRead(7'h01, "midreset_scratch");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
